// File: rtl/network_scheduler.sv
// Network scheduler: launches every trigger once per round, collects their
// done pulses, and reports round completion once the whole network is idle.
module network_scheduler #(
  parameter int unsigned NUM_TRIGGERS = 2
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic                    ap_start,
  output logic                    ap_done,
  output logic                    ap_ready,
  output logic                    ap_idle,
  output logic [NUM_TRIGGERS-1:0] trigger_start,
  input  logic [NUM_TRIGGERS-1:0] trigger_done,
  input  logic [NUM_TRIGGERS-1:0] trigger_idle,
  output logic                    network_idle,
  output logic [31:0]             round_cycles
);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StWait,
    StDone
  } state_e;

  localparam logic [NUM_TRIGGERS-1:0] AllOnes  = '1;
  localparam logic [31:0]             CycleMax = 32'hFFFF_FFFF;

  state_e                  state_q, state_d;
  logic [NUM_TRIGGERS-1:0] done_mask_q, done_mask_d;
  logic [31:0]             round_cycles_q, round_cycles_d;
  logic [31:0]             cycles_inc;
  logic                    network_idle_q;
  logic [1:0]              rst_sync_q;
  logic                    rst_int_n;

  // Reset synchroniser: asserts asynchronously, releases two edges after ap_rst_n rises.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_q[1];

  // Saturating round-length counter increment.
  assign cycles_inc = (round_cycles_q == CycleMax) ? round_cycles_q : round_cycles_q + 32'd1;

  // State, sticky done mask, round counter and registered network idle.
  always_ff @(posedge ap_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q        <= StIdle;
      done_mask_q    <= '0;
      round_cycles_q <= '0;
      network_idle_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      done_mask_q    <= done_mask_d;
      round_cycles_q <= round_cycles_d;
      network_idle_q <= &trigger_idle;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_d        = state_q;
    done_mask_d    = done_mask_q;
    round_cycles_d = round_cycles_q;
    trigger_start  = '0;
    ap_done        = 1'b0;
    ap_ready       = 1'b0;
    ap_idle        = 1'b0;
    unique case (state_q)
      StIdle: begin
        ap_idle = 1'b1;
        if (ap_start) begin
          state_d        = StStart;
          done_mask_d    = '0;
          round_cycles_d = '0;
        end
      end
      StStart: begin
        trigger_start  = AllOnes;
        done_mask_d    = done_mask_q | trigger_done;
        round_cycles_d = cycles_inc;
        state_d        = StWait;
      end
      StWait: begin
        done_mask_d    = done_mask_q | trigger_done;
        round_cycles_d = cycles_inc;
        // Same-cycle done pulses count, so the last trigger need not wait a cycle.
        if (((done_mask_q | trigger_done) == AllOnes) && network_idle_q) begin
          state_d = StDone;
        end
      end
      StDone: begin
        ap_done  = 1'b1;
        ap_ready = 1'b1;
        if (ap_start) begin
          state_d        = StStart;
          done_mask_d    = '0;
          round_cycles_d = '0;
        end else begin
          state_d = StIdle;
        end
      end
    endcase
  end

  assign network_idle = network_idle_q;
  assign round_cycles = round_cycles_q;

endmodule
